alarm_annunciator: RTL and testbench

Downstream consumer of the health indicator's latched alarm (`relay_output` of `health_indicator_top`). It turns the steady alarm level into an audible on/off buzzer cadence and lets an operator silence the buzzer for a bounded time before it re-arms. It also keeps a saturating count of alarm events. It sits between `health_indicator_top` and the board buzzer / front-panel "silenced" LED.

---
 rtl/health_pkg.sv | 22 ++
 rtl/phase_timer.sv | 28 ++
 rtl/alarm_annunciator.sv | 119 +++++++++++
 tb/tb_alarm_annunciator.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/health_pkg.sv
// Shared definitions for the health indicator family: annunciator state
// encodings, default cadence constants and a small sizing helper.
package health_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_BEEP_ON  = 2'd1;
  localparam logic [1:0] ST_BEEP_OFF = 2'd2;
  localparam logic [1:0] ST_SILENCED = 2'd3;

  // Cadence defaults are shared with the blinker so both indicators agree.
  localparam int DEF_ON_CYCLES      = 4;
  localparam int DEF_OFF_CYCLES     = 4;
  localparam int DEF_SILENCE_CYCLES = 16;
  localparam int DEF_COUNT_W        = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that measures one phase of the buzzer cadence.
// A phase of N cycles is timed by loading N-1; expired is high at zero.
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] r_count;

  // Load has priority; otherwise count down and rest at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign expired = (r_count == '0);

endmodule

// File: rtl/alarm_annunciator.sv
// Turns the latched alarm level into an on/off buzzer cadence with an
// operator silence hold-off and a saturating alarm event counter.
module alarm_annunciator
  import health_pkg::*;
#(
  parameter int ON_CYCLES      = DEF_ON_CYCLES,
  parameter int OFF_CYCLES     = DEF_OFF_CYCLES,
  parameter int SILENCE_CYCLES = DEF_SILENCE_CYCLES,
  parameter int COUNT_W        = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               alarm_in,
  input  logic               silence_btn,
  output logic               buzzer,
  output logic               silenced,
  output logic               active,
  output logic [COUNT_W-1:0] event_count
);

  localparam int MAX_CYCLES = max3(ON_CYCLES, OFF_CYCLES, SILENCE_CYCLES);
  localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [TW-1:0] SIL_LOAD = TW'(SILENCE_CYCLES - 1);

  logic [1:0]         r_state;
  logic               r_alarmQ;
  logic               r_btnQ;
  logic [COUNT_W-1:0] r_eventCount;

  logic [1:0]    w_nextState;
  logic          w_load;
  logic [TW-1:0] w_loadVal;
  logic          w_expired;
  logic          w_alarmRise;
  logic          w_silEdge;

  assign w_alarmRise = alarm_in & ~r_alarmQ;
  assign w_silEdge   = silence_btn & ~r_btnQ;

  phase_timer #(
    .W(TW)
  ) u_phaseTimer (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load),
    .load_val(w_loadVal),
    .expired (w_expired)
  );

  // Alarm drop beats everything; a silence edge beats timer expiry.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_loadVal   = ON_LOAD;
    if (!alarm_in) begin
      w_nextState = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_nextState = ST_BEEP_ON;
          w_load      = 1'b1;
          w_loadVal   = ON_LOAD;
        end
        ST_BEEP_ON, ST_BEEP_OFF: begin
          if (w_silEdge) begin
            w_nextState = ST_SILENCED;
            w_load      = 1'b1;
            w_loadVal   = SIL_LOAD;
          end else if (w_expired) begin
            w_nextState = (r_state == ST_BEEP_ON) ? ST_BEEP_OFF : ST_BEEP_ON;
            w_load      = 1'b1;
            w_loadVal   = (r_state == ST_BEEP_ON) ? OFF_LOAD : ON_LOAD;
          end
        end
        ST_SILENCED: begin
          if (w_silEdge) begin
            w_load    = 1'b1;
            w_loadVal = SIL_LOAD;
          end else if (w_expired) begin
            w_nextState = ST_BEEP_ON;
            w_load      = 1'b1;
            w_loadVal   = ON_LOAD;
          end
        end
        default: w_nextState = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_alarmQ <= 1'b0;
      r_btnQ   <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_alarmQ <= alarm_in;
      r_btnQ   <= silence_btn;
    end
  end

  // Counts alarm onsets across drops; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_eventCount <= '0;
    end else if (w_alarmRise && (r_eventCount != '1)) begin
      r_eventCount <= r_eventCount + 1'b1;
    end
  end

  assign buzzer      = (r_state == ST_BEEP_ON);
  assign silenced    = (r_state == ST_SILENCED);
  assign active      = (r_state != ST_IDLE);
  assign event_count = r_eventCount;

endmodule

// File: tb/tb_alarm_annunciator.sv
// Scoreboard bench for alarm_annunciator: a timeline-based reference model
// predicts each cycle's outputs, a monitor compares them after every edge.
module tb_alarm_annunciator;

  localparam int ON_C  = 4;
  localparam int OFF_C = 4;
  localparam int SIL_C = 16;
  localparam int CW    = 8;

  typedef struct packed {
    logic          buzzer;
    logic          silenced;
    logic          active;
    logic [CW-1:0] count;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          alarmIn = 1'b0;
  logic          silenceBtn = 1'b0;
  logic          buzzer;
  logic          silenced;
  logic          active;
  logic [CW-1:0] eventCount;

  exp_t expQ[$];
  int   cycQ[$];
  int   compared = 0;
  int   mismatched = 0;

  // Reference model: beeping is a periodic pattern anchored at beepRef,
  // silence is a window ending at silUntil.
  int  cyc = 0;
  bit  mIdle = 1'b1;
  int  beepRef = 0;
  int  silUntil = 0;
  bit  prevAlarm = 1'b0;
  bit  prevBtn = 1'b0;
  int  mCount = 0;

  alarm_annunciator #(
    .ON_CYCLES     (ON_C),
    .OFF_CYCLES    (OFF_C),
    .SILENCE_CYCLES(SIL_C),
    .COUNT_W       (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .alarm_in   (alarmIn),
    .silence_btn(silenceBtn),
    .buzzer     (buzzer),
    .silenced   (silenced),
    .active     (active),
    .event_count(eventCount)
  );

  always #5 clk = ~clk;

  // Drives one cycle of inputs and pushes the outputs expected after the edge.
  task automatic applyStimulus(input bit a, input bit b, input bit r);
    exp_t e;
    bit   rise;
    bit   sil;
    int   nxt;
    @(negedge clk);
    alarmIn    = a;
    silenceBtn = b;
    reset      = r;
    nxt  = cyc + 1;
    rise = a && !prevAlarm;
    sil  = b && !prevBtn;
    if (r) begin
      mIdle     = 1'b1;
      prevAlarm = 1'b0;
      prevBtn   = 1'b0;
      mCount    = 0;
    end else begin
      if (!a) begin
        mIdle = 1'b1;
      end else if (mIdle) begin
        mIdle    = 1'b0;
        beepRef  = nxt;
        silUntil = nxt;
      end else if (sil) begin
        silUntil = nxt + SIL_C;
        beepRef  = silUntil;
      end
      if (rise && mCount < (1 << CW) - 1) mCount++;
      prevAlarm = a;
      prevBtn   = b;
    end
    e.active   = !mIdle;
    e.silenced = !mIdle && (nxt < silUntil);
    e.buzzer   = e.active && !e.silenced && (((nxt - beepRef) % (ON_C + OFF_C)) < ON_C);
    e.count    = CW'(mCount);
    expQ.push_back(e);
    cycQ.push_back(nxt);
    cyc = nxt;
  endtask

  task automatic checkOutput(input exp_t e, input int c);
    exp_t got;
    got = '{buzzer: buzzer, silenced: silenced, active: active, count: eventCount};
    compared++;
    if (got !== e) begin
      mismatched++;
      $display("[TB] FAIL cycle%0d outputs: got buz=%b sil=%b act=%b cnt=%0d, expected buz=%b sil=%b act=%b cnt=%0d",
               c, got.buzzer, got.silenced, got.active, got.count,
               e.buzzer, e.silenced, e.active, e.count);
    end
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #2;
      if (expQ.size() > 0) checkOutput(expQ.pop_front(), cycQ.pop_front());
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    bit a;
    bit b;
    // Reset held with alarm high, then release: counts as one onset.
    repeat (3) applyStimulus(1, 0, 1);
    repeat (20) applyStimulus(1, 0, 0);
    // Press during beeping and hold; only one silence results.
    applyStimulus(1, 1, 0);
    repeat (6) applyStimulus(1, 1, 0);
    repeat (3) applyStimulus(1, 0, 0);
    // Second press at the tenth silenced cycle extends the window.
    applyStimulus(1, 1, 0);
    repeat (30) applyStimulus(1, 0, 0);
    // Press exactly when the silence window would expire.
    applyStimulus(1, 1, 0);
    repeat (15) applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 0);
    repeat (25) applyStimulus(1, 0, 0);
    // Alarm drop coincident with a silence edge.
    repeat (2) applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0);
    repeat (3) applyStimulus(0, 0, 0);
    // Reset in mid-operation.
    repeat (6) applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 1);
    repeat (5) applyStimulus(1, 0, 0);
    // Randomised alarm and button activity.
    a = 1'b1;
    b = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(15) == 0) a = ~a;
      if ($urandom_range(5) == 0) b = ~b;
      applyStimulus(a, b, 0);
    end
    // Saturate the event counter, then clear it with reset.
    applyStimulus(1, 0, 1);
    for (int i = 0; i < 260; i++) begin
      applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 0);
    end
    repeat (4) applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 1);
    repeat (2) applyStimulus(0, 0, 0);
    repeat (3) @(negedge clk);
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d pending expectations, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
